// File: rtl/simd_lane_accumulator_if.sv
// Bundled start/beat/result signals of simd_lane_accumulator.
// Input beats and results both use valid/ready: a transfer happens on any rising clk edge where valid && ready are both high.
interface simd_lane_accumulator_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic [1:0]       width;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ovf;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W+1:0] out_sum;
  logic             out_ovf;
  logic             busy;

  modport master (
    output start, len, width, in_valid, in_data, in_ovf, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  start, len, width, in_valid, in_data, in_ovf, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/simd_lane_accumulator.sv
// Lane-wise accumulator of packed SIMD results with a final horizontal sum.
// Define SIMD_ACC_SAT_EN to saturate lane accumulators; otherwise they wrap.
module simd_lane_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  simd_lane_accumulator_if.slave     bus,
  output logic [1:0]                 dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_REDUCE = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       width_q, width_d;
  logic [ACC_W-1:0] acc_q [4];
  logic [ACC_W-1:0] acc_d [4];
  logic             sticky_q, sticky_d;
  logic [ACC_W+1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] lane [4];
  logic [ACC_W:0]   lane_sum [4];
  logic [ACC_W-1:0] lane_next [4];
  logic [3:0]       lane_carry;
  logic             hs;

  assign hs = bus.in_valid && (state_q == S_ACCUM);

  // Unused lanes (and the reserved width codes) contribute zero.
  always_comb begin
    for (int i = 0; i < 4; i++) lane[i] = '0;
    case (width_q)
      2'b00: for (int i = 0; i < 4; i++) lane[i] = ACC_W'(bus.in_data[8*i +: 8]);
      2'b01: begin
        lane[0] = ACC_W'(bus.in_data[15:0]);
        lane[1] = ACC_W'(bus.in_data[31:16]);
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++) begin
      lane_sum[i]   = {1'b0, acc_q[i]} + {1'b0, lane[i]};
      lane_carry[i] = lane_sum[i][ACC_W];
`ifdef SIMD_ACC_SAT_EN
      lane_next[i]  = lane_carry[i] ? {ACC_W{1'b1}} : lane_sum[i][ACC_W-1:0];
`else
      lane_next[i]  = lane_sum[i][ACC_W-1:0];
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    width_d     = width_q;
    sticky_d    = sticky_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    for (int i = 0; i < 4; i++) acc_d[i] = acc_q[i];
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < 4; i++) acc_d[i] = '0;
          sticky_d    = 1'b0;
          remaining_d = bus.len;
          width_d     = bus.width;
          state_d     = (bus.len != '0) ? S_ACCUM : S_REDUCE;
        end
      end
      S_ACCUM: begin
        if (hs) begin
          for (int i = 0; i < 4; i++) acc_d[i] = lane_next[i];
          remaining_d = remaining_q - CNT_W'(1);
          sticky_d    = sticky_q | bus.in_ovf | (|lane_carry);
          if (remaining_q == CNT_W'(1)) state_d = S_REDUCE;
        end
      end
      S_REDUCE: begin
        sum_d   = (ACC_W+2)'(acc_q[0]) + (ACC_W+2)'(acc_q[1])
                + (ACC_W+2)'(acc_q[2]) + (ACC_W+2)'(acc_q[3]);
        ovf_d   = sticky_q;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      width_q     <= 2'b00;
      sticky_q    <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      width_q     <= width_d;
      sticky_q    <= sticky_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      for (int i = 0; i < 4; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign bus.in_ready  = (state_q == S_ACCUM);
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = ovf_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/simd_lane_accumulator.md
# simd_lane_accumulator

Downstream consumer of the SIMD unit's packed 32-bit results and overflow flag. It accumulates a programmed number of result beats lane by lane, in 4x8-bit or 2x16-bit lanes. At the end of the run it reduces the lanes to one horizontal sum and presents it on a valid/ready output. Together with the SIMD MUL lanes it forms the multiply-accumulate / dot-product path of the DSP datapath.

## Interface
- ACC_W, 24: per-lane accumulator width in bits; must be >= 16.
- CNT_W, 8: width of the beat-count field.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a run; honoured only in IDLE.
- len  input  CNT_W  number of input beats in the run; sampled with start.
- width  input  2  lane format; sampled with start. 00 = four 8-bit lanes, 01 = two 16-bit lanes, others = no lanes (every beat adds 0).
- in_valid  input  1  in_data / in_ovf valid.
- in_data  input  32  packed SIMD result.
- in_ovf  input  1  SIMD overflow flag for this beat.
- in_ready  output  1  block accepts a beat this cycle.
- out_valid  output  1  out_sum / out_ovf valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W+2  horizontal sum of all lane accumulators.
- out_ovf  output  1  sticky overflow for the run.
- busy  output  1  high in any state other than IDLE.

## Operation
State machine with four states:
- IDLE
  - in_ready=0.
  - On start: clear acc0..acc3 and the sticky overflow; latch len into a remaining counter; latch width.
  - Next state is ACCUM if len!=0, otherwise REDUCE.
- ACCUM
  - in_ready=1.
  - Each handshake (in_valid & in_ready) adds the unsigned, zero-extended lanes:
    - width 00: acc_i += in_data[8i+7:8i], i = 0..3.
    - width 01: acc0 += in_data[15:0], acc1 += in_data[31:16].
  - On each handshake: remaining decrements; sticky |= in_ovf | any lane accumulator overflow.
  - The handshake that makes remaining reach 0 moves the FSM to REDUCE.
  - Cycles with in_valid=0 hold all state.
- REDUCE (one cycle)
  - in_ready=0.
  - out_sum <= acc0+acc1+acc2+acc3, computed at ACC_W+2 bits, so this addition never overflows.
  - out_ovf <= sticky.
  - Next state is HOLD.
- HOLD
  - out_valid=1.
  - out_sum / out_ovf are held stable until out_valid & out_ready, then the FSM returns to IDLE and out_valid drops.
- start outside IDLE is ignored. start in the same cycle as the HOLD->IDLE exit is also ignored.
- Lane accumulator overflow means a carry out of bit ACC_W-1. Behaviour on overflow is defined under Configuration.

## Timing
- Reset values: in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0; state IDLE; accumulators and counter 0.
- Reset asserted mid-run aborts immediately. No out_valid is produced for the aborted run.
- start sampled at cycle t: busy=1 and in_ready=1 from cycle t+1.
- Last beat accepted at cycle t: REDUCE at t+1, out_valid=1 at t+2.
- len=0, start at t: out_valid=1 at t+2 with out_sum=0, out_ovf=0.
- Maximum throughput: one beat per cycle in ACCUM.
- out_sum and out_ovf are registered. They keep the last result value while in IDLE and are updated only in REDUCE.

## Configuration
- SIMD_ACC_SAT_EN defined: each lane accumulator saturates at 2^ACC_W-1 on overflow and sets sticky.
- SIMD_ACC_SAT_EN undefined: each lane accumulator wraps modulo 2^ACC_W; the carry still sets sticky.

## Test plan
- Basic 8-bit run: width=00, len=2, beats 0x01020304 then 0x10101010 -> out_sum=0x4A (74), out_ovf=0, out_valid two cycles after the second beat.
- 16-bit run: width=01, len=1, beat 0xFFFF0001 -> out_sum=0x10000, out_ovf=0.
- Empty run and overflow propagation:
  - len=0, start at cycle 0 -> out_valid=1 at cycle 2, out_sum=0.
  - Separate run, len=3, in_ovf=1 on beat 2 only -> out_ovf=1.
- Backpressure and flow control:
  - out_ready held low 5 cycles in HOLD -> out_valid and out_sum stable throughout; a start pulse during HOLD is ignored; the FSM returns to IDLE the cycle after out_ready=1.
  - in_valid gaps mid-run -> accumulators and counter unchanged during the gaps.
- Overflow handling, ACC_W=16, width=01, len=2, beats 0x0000FFFF then 0x00000001:
  - With SIMD_ACC_SAT_EN -> out_sum=0xFFFF, out_ovf=1.
  - Without it -> out_sum=0, out_ovf=1.
- Reset mid-run: rst_n low after 1 of 3 beats -> all outputs 0 immediately. A new run (len=1, beat 0x01010101, width=00) -> out_sum=4.
